// File: rtl/clock_pkg.sv
// Shared clock/chime definitions: field widths, day constants, chime FSM
// state encoding and the 24h-hour to 12h-strike mapping.
`timescale 1ns/1ps
package clock_pkg;

    localparam int unsigned HOUR_W        = 5;
    localparam int unsigned MIN_W         = 6;
    localparam int unsigned SEC_W         = 6;
    localparam int unsigned CNT_W         = 5;
    localparam int unsigned HOURS_PER_DAY = 24;
    localparam int unsigned MAX_STRIKES   = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHIME    = 2'd1,
        COOLDOWN = 2'd2
    } chime_state_t;

    // Midnight strikes twelve; afternoon hours fold back onto 1..11.
    function automatic logic [CNT_W-1:0] hour_to_strikes(input logic [HOUR_W-1:0] h);
        logic [CNT_W-1:0] strikes;
        if (h == '0) begin
            strikes = CNT_W'(MAX_STRIKES);
        end else if (h <= HOUR_W'(MAX_STRIKES)) begin
            strikes = CNT_W'(h);
        end else begin
            strikes = CNT_W'(h - HOUR_W'(MAX_STRIKES));
        end
        return strikes;
    endfunction

endpackage

// File: rtl/chime_hold_timer.sv
// Saturating 1 Hz tick counter measuring how long the chime enable has
// been held. 'expire' flags the tick that brings the count up to HOLD_SEC
// so the controller can drop the enable on that same edge.
`timescale 1ns/1ps
module chime_hold_timer
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_SEC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             tick_1hz,
    output logic [CNT_W-1:0] count,
    output logic             expire,
    output logic             done
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_SEC - 1);
    localparam logic [CNT_W-1:0] HOLD_FULL = CNT_W'(HOLD_SEC);

    // Count enabled ticks, saturating at all-ones; clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && tick_1hz && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Flag the counting tick that reaches the hold window, plus a level once reached.
    always_comb begin
        expire = enable && tick_1hz && (count >= HOLD_LAST);
        done   = (count >= HOLD_FULL);
    end

endmodule

// File: rtl/hour_chime_ctrl.sv
// Top-of-hour strike controller. Detects hh:00:00, latches a 1..12 strike
// count and holds chime_en for HOLD_SEC seconds, then waits out the :00
// minute in COOLDOWN so the same hour cannot retrigger.
// Optional feature macro: HOUR_CHIME_QUIET_EN (suppress chimes during the
// [QUIET_START, QUIET_END) hour window).
`timescale 1ns/1ps
module hour_chime_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_SEC    = 16,
    parameter int unsigned QUIET_START = 22,
    parameter int unsigned QUIET_END   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] hour,
    input  logic [MIN_W-1:0]  minute,
    input  logic [SEC_W-1:0]  second,
    input  logic              chime_on,
    input  logic              set_mode,
    output logic              chime_en,
    output logic [CNT_W-1:0]  chime_count,
    output logic              busy
);

    chime_state_t     state;
    logic             match;
    logic             quiet;
    logic             hold_clear;
    logic             hold_enable;
    logic             hold_expire;
    logic             hold_done;
    logic [CNT_W-1:0] hold_count;

    // Top-of-hour detect; out-of-range hours never match.
    always_comb begin
        match = (minute == '0) && (second == '0) &&
                (hour <= HOUR_W'(HOURS_PER_DAY - 1));
    end

`ifdef HOUR_CHIME_QUIET_EN
    localparam logic [HOUR_W-1:0] Q_START = HOUR_W'(QUIET_START);
    localparam logic [HOUR_W-1:0] Q_END   = HOUR_W'(QUIET_END);

    // Quiet-window membership; the window wraps midnight when start > end.
    always_comb begin
        if (Q_START < Q_END) begin
            quiet = (hour >= Q_START) && (hour < Q_END);
        end else if (Q_START > Q_END) begin
            quiet = (hour >= Q_START) || (hour < Q_END);
        end else begin
            quiet = 1'b0;
        end
    end
`else
    // No quiet gating in this build.
    always_comb begin
        quiet = 1'b0;
    end
`endif

    // Timer runs only while chiming; held clear everywhere else so entry starts at zero.
    always_comb begin
        hold_enable = (state == CHIME);
        hold_clear  = (state != CHIME);
    end

    chime_hold_timer #(
        .HOLD_SEC (HOLD_SEC)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clear    (hold_clear),
        .enable   (hold_enable),
        .tick_1hz (tick_1hz),
        .count    (hold_count),
        .expire   (hold_expire),
        .done     (hold_done)
    );

    // Chime FSM with registered enable, strike count and busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            chime_en    <= 1'b0;
            chime_count <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (match && chime_on && !set_mode) begin
                        if (quiet) begin
                            state    <= COOLDOWN;
                            chime_en <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            state       <= CHIME;
                            chime_en    <= 1'b1;
                            chime_count <= hour_to_strikes(hour);
                            busy        <= 1'b1;
                        end
                    end
                end
                CHIME: begin
                    if (!chime_on || set_mode || hold_expire || hold_done) begin
                        state    <= COOLDOWN;
                        chime_en <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                COOLDOWN: begin
                    chime_en <= 1'b0;
                    if (minute != '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    chime_en <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hour_chime_ctrl.sv
// Directed self-checking bench for hour_chime_ctrl.
`timescale 1ns/1ps
module tb_hour_chime_ctrl;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       chime_on;
    logic       set_mode;
    logic       chime_en;
    logic [4:0] chime_count;
    logic       busy;

    int n_cmp;
    int n_err;

    hour_chime_ctrl #(
        .HOLD_SEC    (16),
        .QUIET_START (22),
        .QUIET_END   (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .chime_on    (chime_on),
        .set_mode    (set_mode),
        .chime_en    (chime_en),
        .chime_count (chime_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour   = 5'(h);
        minute = 6'(m);
        second = 6'(s);
    endtask

    // Leave CHIME via chime_on=0, then exit COOLDOWN via a non-zero minute.
    task automatic to_idle();
        chime_on = 1'b0;
        minute   = 6'd1;
        step();
        step();
        step();
        chime_on = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick_1hz = 1'b0;
        chime_on = 1'b1;
        set_mode = 1'b0;
        set_time(13, 59, 59);
        step();
        step();
        n_cmp++;
        if ({chime_en, busy, chime_count} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b busy=%b cnt=%0d want 0/0/0", chime_en, busy, chime_count);
        end
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (chime_en !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_1359: got en=%b busy=%b want 0/0", chime_en, busy);
        end
    endtask

    task automatic test_basic_strike();
        set_time(14, 0, 0);
        #1;
        n_cmp++;
        if (chime_en !== 1'b0) begin
            n_err++;
            $display("FAIL en_before_edge: got %b want 0", chime_en);
        end
        step();
        n_cmp++;
        if (chime_en !== 1'b1 || chime_count !== 5'd2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL strike_14: got en=%b cnt=%0d busy=%b want 1/2/1", chime_en, chime_count, busy);
        end
        for (int i = 1; i <= 15; i++) begin
            pulse();
            step();
            n_cmp++;
            if (chime_en !== 1'b1 || chime_count !== 5'd2) begin
                n_err++;
                $display("FAIL hold_tick%0d: got en=%b cnt=%0d want 1/2", i, chime_en, chime_count);
            end
        end
        pulse();
        n_cmp++;
        if (chime_en !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL drop_tick16: got en=%b busy=%b want 0/1", chime_en, busy);
        end
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (busy !== 1'b1 || chime_en !== 1'b0 || chime_count !== 5'd2) begin
            n_err++;
            $display("FAIL cooldown_hold: got busy=%b en=%b cnt=%0d want 1/0/2", busy, chime_en, chime_count);
        end
        minute = 6'd1;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL cooldown_exit: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_hour_map();
        int hrs [3] = '{0, 12, 1};
        int exp [3] = '{12, 12, 1};
        for (int i = 0; i < 3; i++) begin
            set_time(hrs[i], 59, 0);
            step();
            set_time(hrs[i], 0, 0);
            step();
            n_cmp++;
            if (chime_en !== 1'b1 || chime_count !== 5'(exp[i])) begin
                n_err++;
                $display("FAIL map_h%0d: got en=%b cnt=%0d want 1/%0d", hrs[i], chime_en, chime_count, exp[i]);
            end
            to_idle();
        end
    endtask

    task automatic test_hour_invalid();
        set_time(25, 0, 0);
        step();
        step();
        n_cmp++;
        if (chime_en !== 1'b0 || busy !== 1'b0 || chime_count !== 5'd1) begin
            n_err++;
            $display("FAIL hour25: got en=%b busy=%b cnt=%0d want 0/0/1", chime_en, busy, chime_count);
        end
        minute = 6'd1;
        step();
    endtask

    task automatic test_retrigger();
        int  rises;
        logic prev;
        rises = 0;
        prev  = chime_en;
        set_time(9, 0, 0);
        for (int i = 0; i < 70; i++) begin
            pulse();
            if (chime_en === 1'b1 && prev !== 1'b1) rises++;
            prev = chime_en;
            step();
            if (chime_en === 1'b1 && prev !== 1'b1) rises++;
            prev = chime_en;
        end
        n_cmp++;
        if (rises !== 1) begin
            n_err++;
            $display("FAIL retrigger_windows: got %0d want 1", rises);
        end
        n_cmp++;
        if (busy !== 1'b1 || chime_count !== 5'd9) begin
            n_err++;
            $display("FAIL retrigger_busy: got busy=%b cnt=%0d want 1/9", busy, chime_count);
        end
        minute = 6'd1;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL retrigger_exit: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort();
        set_time(10, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            pulse();
            step();
        end
        n_cmp++;
        if (chime_en !== 1'b1 || chime_count !== 5'd10) begin
            n_err++;
            $display("FAIL abort_pre: got en=%b cnt=%0d want 1/10", chime_en, chime_count);
        end
        set_mode = 1'b1;
        pulse();
        n_cmp++;
        if (chime_en !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_drop: got en=%b busy=%b want 0/1", chime_en, busy);
        end
        step();
        set_mode = 1'b0;
        step();
        step();
        n_cmp++;
        if (chime_en !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_cooldown: got en=%b busy=%b want 0/1", chime_en, busy);
        end
        minute = 6'd5;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_exit: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_chime_off_then_on();
        chime_on = 1'b0;
        set_time(3, 0, 0);
        step();
        step();
        step();
        n_cmp++;
        if (chime_en !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL off_no_chime: got en=%b busy=%b want 0/0", chime_en, busy);
        end
        chime_on = 1'b1;
        step();
        n_cmp++;
        if (chime_en !== 1'b1 || chime_count !== 5'd3) begin
            n_err++;
            $display("FAIL late_on: got en=%b cnt=%0d want 1/3", chime_en, chime_count);
        end
        to_idle();
    endtask

    task automatic test_set_mode_release();
        set_mode = 1'b1;
        set_time(5, 0, 0);
        step();
        step();
        n_cmp++;
        if (chime_en !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL setmode_block: got en=%b busy=%b want 0/0", chime_en, busy);
        end
        set_mode = 1'b0;
        step();
        n_cmp++;
        if (chime_en !== 1'b1 || chime_count !== 5'd5) begin
            n_err++;
            $display("FAIL setmode_release: got en=%b cnt=%0d want 1/5", chime_en, chime_count);
        end
    endtask

    task automatic test_reset_mid_chime();
        pulse();
        step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({chime_en, busy, chime_count} !== 7'b0) begin
            n_err++;
            $display("FAIL async_reset: got en=%b busy=%b cnt=%0d want 0/0/0", chime_en, busy, chime_count);
        end
        set_time(10, 0, 5);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if ({chime_en, busy, chime_count} !== 7'b0) begin
            n_err++;
            $display("FAIL post_reset_1005: got en=%b busy=%b cnt=%0d want 0/0/0", chime_en, busy, chime_count);
        end
    endtask

`ifdef HOUR_CHIME_QUIET_EN
    task automatic test_quiet();
        int hrs [2] = '{23, 6};
        for (int i = 0; i < 2; i++) begin
            set_time(hrs[i], 59, 0);
            step();
            set_time(hrs[i], 0, 0);
            step();
            n_cmp++;
            if (chime_en !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL quiet_h%0d: got en=%b busy=%b want 0/1", hrs[i], chime_en, busy);
            end
            minute = 6'd1;
            step();
        end
        set_time(7, 0, 0);
        step();
        n_cmp++;
        if (chime_en !== 1'b1 || chime_count !== 5'd7) begin
            n_err++;
            $display("FAIL quiet_h7: got en=%b cnt=%0d want 1/7", chime_en, chime_count);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
`ifdef HOUR_CHIME_QUIET_EN
        test_quiet();
`else
        test_basic_strike();
        test_hour_map();
        test_hour_invalid();
        test_retrigger();
        test_abort();
        test_chime_off_then_on();
        test_set_mode_release();
        test_reset_mid_chime();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
